// File: rtl/complex_pkg.sv
// Shared definitions for the complex arithmetic path: default word widths,
// accumulator FSM states and the complex product word.
package complex_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic [IN_W_DEF-1:0] re;
        logic [IN_W_DEF-1:0] im;
    } cplx_word_t;

endpackage

// File: rtl/cplx_acc_add.sv
// One accumulator component: sign-extend the incoming term, add it modulo
// 2**ACC_W, and flag signed overflow of that add.
module cplx_acc_add #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [IN_W-1:0]  i_term,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W-1:0] w_ext;

    assign w_ext = ACC_W'($signed(i_term));
    assign o_sum = i_acc + w_ext;
    // Same-sign operands producing a different-sign result is a wrap.
    assign o_ovf = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                   (o_sum[ACC_W-1] != i_acc[ACC_W-1]);

endmodule

// File: rtl/complex_mac_accumulator.sv
// Complex dot-product accumulator: sums signed (re, im) product terms until
// in_last or MAX_TERMS, then holds the result on a valid/ready output.
module complex_mac_accumulator
    import complex_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_re,
    input  logic [IN_W-1:0]  in_im,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_re,
    output logic [ACC_W-1:0] acc_im,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf,
    output logic             forced
);

    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    logic [ACC_W-1:0] r_acc_re;
    logic [ACC_W-1:0] r_acc_im;
    logic [ACC_W-1:0] w_sum_re;
    logic [ACC_W-1:0] w_sum_im;
    logic             w_ovf_re;
    logic             w_ovf_im;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_ovf;
    logic             r_forced;
    logic             w_accept;
    logic             w_full;
    logic             w_close;
    logic             w_consume;

    cplx_acc_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add_re (
        .i_acc  (r_acc_re),
        .i_term (in_re),
        .o_sum  (w_sum_re),
        .o_ovf  (w_ovf_re)
    );

    cplx_acc_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add_im (
        .i_acc  (r_acc_im),
        .i_term (in_im),
        .o_sum  (w_sum_im),
        .o_ovf  (w_ovf_im)
    );

    // Handshakes are decoded from the state register directly so the
    // ready/valid outputs never sit in a combinational loop with them.
    assign w_accept  = in_valid && (r_state == ACCUM);
    assign w_consume = out_ready && (r_state == DONE);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_full    = (w_cnt_inc == CNT_W'(MAX_TERMS));
    assign w_close   = w_accept && (in_last || w_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (w_close) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_forced <= 1'b0;
        end else if (w_consume) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_forced <= 1'b0;
        end else if (w_accept) begin
            r_acc_re <= w_sum_re;
            r_acc_im <= w_sum_im;
            r_cnt    <= w_cnt_inc;
            r_ovf    <= r_ovf | w_ovf_re | w_ovf_im;
            // Only the closing term can hit the limit, so this is 0 mid-vector.
            r_forced <= w_full && !in_last;
        end
    end

    assign acc_re   = r_acc_re;
    assign acc_im   = r_acc_im;
    assign term_cnt = r_cnt;
    assign ovf      = r_ovf;
    assign forced   = r_forced;

endmodule

// File: tb/tb_complex_mac_accumulator.sv
// Bench for complex_mac_accumulator: three configurations (default, 17-bit
// accumulator, 4-term limit) checked against a plain-arithmetic model.
module tb_complex_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld;
    logic [15:0] in_re, in_im;
    logic        in_last, out_ready;

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [23:0] are0, aim0, are2, aim2;
    logic [16:0] are1, aim1;
    logic [8:0]  cnt0, cnt1;
    logic [2:0]  cnt2;
    logic        of0, of1, of2, fo0, fo1, fo2;

    int checks = 0;
    int errors = 0;
    int q_re[$];
    int q_im[$];

    always #5 clk = ~clk;

    complex_mac_accumulator u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(ir0),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .acc_re(are0), .acc_im(aim0),
        .term_cnt(cnt0), .ovf(of0), .forced(fo0));

    complex_mac_accumulator #(.ACC_W(17)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(ir1),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .acc_re(are1), .acc_im(aim1),
        .term_cnt(cnt1), .ovf(of1), .forced(fo1));

    complex_mac_accumulator #(.MAX_TERMS(4), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(ir2),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(ov2), .out_ready(out_ready), .acc_re(are2), .acc_im(aim2),
        .term_cnt(cnt2), .ovf(of2), .forced(fo2));

    function automatic int awid(input int sel);
        return (sel == 1) ? 17 : 24;
    endfunction

    function automatic int maxt(input int sel);
        return (sel == 2) ? 4 : 256;
    endfunction

    function automatic longint wrapv(input longint s, input longint lim);
        longint m;
        m = 2 * lim;
        return ((s + lim) % m + m) % m - lim;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int r, input int i);
        q_re.push_back(r);
        q_im.push_back(i);
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int sel,
                             input longint er, input longint ei, input int ec,
                             input bit eo, input bit ef, input bit ev, input bit erd);
        logic signed [63:0] o_re, o_im, o_cnt, o_of, o_fo, o_ov, o_ir;
        case (sel)
            0: begin
                o_re = $signed(are0); o_im = $signed(aim0); o_cnt = cnt0;
                o_of = of0; o_fo = fo0; o_ov = ov0; o_ir = ir0;
            end
            1: begin
                o_re = $signed(are1); o_im = $signed(aim1); o_cnt = cnt1;
                o_of = of1; o_fo = fo1; o_ov = ov1; o_ir = ir1;
            end
            default: begin
                o_re = $signed(are2); o_im = $signed(aim2); o_cnt = cnt2;
                o_of = of2; o_fo = fo2; o_ov = ov2; o_ir = ir2;
            end
        endcase
        chk({tag, ".acc_re"},    o_re,  er);
        chk({tag, ".acc_im"},    o_im,  ei);
        chk({tag, ".term_cnt"},  o_cnt, ec);
        chk({tag, ".ovf"},       o_of,  eo);
        chk({tag, ".forced"},    o_fo,  ef);
        chk({tag, ".out_valid"}, o_ov,  ev);
        chk({tag, ".in_ready"},  o_ir,  erd);
    endtask

    // Drives the queued terms into DUT `sel`, checks running sums, the held
    // result and the clear after consumption. gap < 0 means random idle gaps.
    task automatic run_vec(input string tag, input int sel, input bit last_fin,
                           input int gap);
        longint lim, s_re, s_im;
        longint p_re[$], p_im[$];
        bit     p_of[$];
        bit     eo, ef;
        int     n, hold;
        n    = q_re.size();
        lim  = longint'(1) << (awid(sel) - 1);
        s_re = 0; s_im = 0; eo = 0;
        for (int i = 0; i < n; i++) begin
            s_re += q_re[i];
            s_im += q_im[i];
            if (s_re >= lim || s_re < -lim || s_im >= lim || s_im < -lim) eo = 1;
            s_re = wrapv(s_re, lim);
            s_im = wrapv(s_im, lim);
            p_re.push_back(s_re);
            p_im.push_back(s_im);
            p_of.push_back(eo);
        end
        ef = (n == maxt(sel)) && !last_fin;

        for (int i = 0; i < n; i++) begin
            repeat ((gap < 0) ? $urandom_range(0, 2) : gap) tick();
            vld[sel]  = 1'b1;
            in_re     = 16'(q_re[i]);
            in_im     = 16'(q_im[i]);
            in_last   = last_fin && (i == n - 1);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            vld       = '0;
            in_last   = 1'b0;
            out_ready = 1'b0;
            if (i < n - 1)
                check_all({tag, ".run"}, sel, p_re[i], p_im[i], i + 1, p_of[i], 1'b0, 1'b0, 1'b1);
        end

        hold = $urandom_range(0, 3);
        repeat (hold) begin
            check_all({tag, ".held"}, sel, s_re, s_im, n, eo, ef, 1'b1, 1'b0);
            tick();
        end
        check_all({tag, ".done"}, sel, s_re, s_im, n, eo, ef, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_all({tag, ".clear"}, sel, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        q_re.delete();
        q_im.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit lst;
        rst_n = 1'b0; vld = '0; in_re = '0; in_im = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) check_all("reset", s, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();

        add(-12, 59); add(0, -30);
        run_vec("two_term", 0, 1'b1, 0);

        // Back-pressure: result (1,2) held while (5,5,last) waits upstream.
        vld[0] = 1'b1; in_re = 16'd1; in_im = 16'd2; in_last = 1'b1;
        tick();
        in_re = 16'd5; in_im = 16'd5;
        repeat (5) begin
            check_all("bp.hold", 0, 1, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_all("bp.consume", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        vld = '0; in_last = 1'b0;
        check_all("bp.next", 0, 5, 5, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_all("bp.clear", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        add(32767, 0); add(32767, 0); add(32767, 0);
        run_vec("ovf", 1, 1'b1, 0);
        check_all("ovf.after", 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1, 1);
        run_vec("ovf_next", 1, 1'b1, 0);

        repeat (4) add(1, -1);
        run_vec("forced", 2, 1'b0, 0);
        repeat (4) add(1, -1);
        run_vec("limit_last", 2, 1'b1, 0);

        // Reset mid-vector, asserted and released between clock edges.
        vld[0] = 1'b1; in_re = 16'd100; in_im = 16'd100; in_last = 1'b0;
        repeat (3) tick();
        vld = '0;
        check_all("rst.pre", 0, 300, 300, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1 check_all("rst.async", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        repeat (2) begin
            tick();
            check_all("rst.idle", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        add(7, -3);
        run_vec("single", 0, 1'b1, 0);

        add(-7, 3); add(9, 1);
        run_vec("gapped", 0, 1'b1, 3);

        repeat (12) begin
            n = $urandom_range(1, 8);
            repeat (n) add(rnd16(), rnd16());
            run_vec("rnd_dflt", 0, 1'b1, -1);
        end
        repeat (6) begin
            n = $urandom_range(1, 5);
            repeat (n) add(rnd16(), rnd16());
            run_vec("rnd_acc17", 1, 1'b1, -1);
        end
        repeat (8) begin
            n   = $urandom_range(1, 4);
            lst = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            repeat (n) add(rnd16(), rnd16());
            run_vec("rnd_max4", 2, lst, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
